// File: rtl/bytebasher_pkg.sv
// Shared types and constants for the whack-a-mole round controller and its window timer.
// Latency: n/a; backpressure: n/a.
package bytebasher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_SHOW   = 3'd3,
      ST_HIT    = 3'd4,
      ST_MISS   = 3'd5,
      ST_GAP    = 3'd6,
      ST_OVER   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      BOX_NONE = 3'd0,
      BOX1     = 3'd1,
      BOX2     = 3'd2,
      BOX3     = 3'd3,
      BOX4     = 3'd4,
      BOX5     = 3'd5
   } box_e;

   localparam int SCORE_W = 8;
   localparam int MISS_W  = 4;
   localparam int ROUND_W = 8;
   localparam int TICK_W  = 4;
   localparam int RETRY_W = 4;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/tick_window_timer.sv
// Load/decrement-on-tick window counter; o_done flags the tick that takes it from 1 to 0.
// Latency: o_done is combinational on i_tick; no backpressure.
module tick_window_timer
   import bytebasher_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_tick,
   input  logic              i_load,
   input  logic [TICK_W-1:0] i_load_val,
   output logic              o_done
);

   logic [TICK_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = i_tick && (r_cnt == TICK_W'(1));

endmodule

// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: draws a box via the LFSR, shows it for a tick window, scores hits/misses.
// Latency: start to flash_en 3 cycles (+2 per re-draw); no backpressure. MOLE_SPEEDUP_EN shrinks the window.
module mole_round_controller
   import bytebasher_pkg::*;
#(
   parameter int ROUNDS         = 20,
   parameter int MAX_MISSES     = 3,
   parameter int SHOW_TICKS     = 3,
   parameter int GAP_TICKS      = 1,
   parameter int RETRY_MAX      = 3,
   parameter int MIN_SHOW_TICKS = 1
)(
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic               tick,
   input  logic               start,
   input  logic [2:0]         box_sel,
   input  logic               hit_valid,
   input  logic [2:0]         hit_box,
   output logic               lfsr_step,
   output logic [2:0]         active_box,
   output logic               flash_en,
   output logic               hit_flag,
   output logic               miss_flag,
   output logic [SCORE_W-1:0] score,
   output logic [MISS_W-1:0]  misses,
   output logic [ROUND_W-1:0] round_count,
   output logic               game_over
);

   localparam logic [TICK_W-1:0]  LP_SHOW       = TICK_W'(SHOW_TICKS);
   localparam logic [TICK_W-1:0]  LP_MIN        = TICK_W'(MIN_SHOW_TICKS);
   localparam logic [TICK_W-1:0]  LP_GAP        = TICK_W'(GAP_TICKS);
   localparam logic [RETRY_W-1:0] LP_RETRY_MAX  = RETRY_W'(RETRY_MAX);
   localparam logic [MISS_W-1:0]  LP_MAX_MISSES = MISS_W'(MAX_MISSES);
   localparam logic [ROUND_W-1:0] LP_ROUNDS     = ROUND_W'(ROUNDS);

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          r_active_box;
   logic [2:0]          r_last_box;
   logic [RETRY_W-1:0]  r_retries;
   logic [SCORE_W-1:0]  r_score;
   logic [MISS_W-1:0]   r_misses;
   logic [ROUND_W-1:0]  r_rounds;
   logic [SCORE_W-1:0]  w_score_inc;
   logic [TICK_W-1:0]   w_show_len;
   logic [TICK_W-1:0]   w_load_val;
   logic                w_load;
   logic                w_done;
   logic                w_redraw;
   logic                w_end;

   assign w_score_inc = sat_inc(r_score);
   assign w_redraw    = (box_sel == r_last_box) && (r_retries < LP_RETRY_MAX);
   assign w_end       = (r_misses == LP_MAX_MISSES) || (r_rounds == LP_ROUNDS);

   tick_window_timer u_timer (
      .i_clk      (CLOCK_50),
      .i_rst_n    (resetn),
      .i_tick     (tick),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_done     (w_done)
   );

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // One timer serves the show window, the feedback hold and the gap; it is reloaded on each entry.
   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_load_val  = w_show_len;
      lfsr_step   = 1'b0;
      flash_en    = 1'b0;
      hit_flag    = 1'b0;
      miss_flag   = 1'b0;
      game_over   = 1'b0;
      active_box  = BOX_NONE;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_ARM;
         end
         ST_ARM: begin
            lfsr_step = 1'b1;
            w_next    = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (w_redraw) begin
               w_next = ST_ARM;
            end else begin
               w_next = ST_SHOW;
               w_load = 1'b1;
            end
         end
         ST_SHOW: begin
            flash_en   = 1'b1;
            active_box = r_active_box;
            if (hit_valid) begin
               w_next     = (hit_box == r_active_box) ? ST_HIT : ST_MISS;
               w_load     = 1'b1;
               w_load_val = TICK_W'(1);
            end else if (w_done) begin
               w_next     = ST_MISS;
               w_load     = 1'b1;
               w_load_val = TICK_W'(1);
            end
         end
         ST_HIT, ST_MISS: begin
            hit_flag   = (r_state == ST_HIT);
            miss_flag  = (r_state == ST_MISS);
            active_box = r_active_box;
            if (w_done) begin
               if (w_end) begin
                  w_next = ST_OVER;
               end else begin
                  w_next     = ST_GAP;
                  w_load     = 1'b1;
                  w_load_val = LP_GAP;
               end
            end
         end
         ST_GAP: begin
            if (w_done) w_next = ST_ARM;
         end
         ST_OVER: begin
            game_over = 1'b1;
            if (start) w_next = ST_ARM;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_active_box <= BOX_NONE;
         r_last_box   <= BOX_NONE;
         r_retries    <= '0;
         r_score      <= '0;
         r_misses     <= '0;
         r_rounds     <= '0;
      end else begin
         case (r_state)
            ST_SAMPLE: begin
               if (w_redraw) begin
                  r_retries <= r_retries + 1'b1;
               end else begin
                  r_active_box <= box_sel;
                  r_last_box   <= box_sel;
                  r_retries    <= '0;
               end
            end
            ST_SHOW: begin
               if (w_next == ST_HIT) begin
                  r_score  <= w_score_inc;
                  r_rounds <= r_rounds + 1'b1;
               end else if (w_next == ST_MISS) begin
                  r_misses <= r_misses + 1'b1;
                  r_rounds <= r_rounds + 1'b1;
               end
            end
            ST_OVER: begin
               if (start) begin
                  r_score    <= '0;
                  r_misses   <= '0;
                  r_rounds   <= '0;
                  r_last_box <= BOX_NONE;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MOLE_SPEEDUP_EN
   logic [TICK_W-1:0] r_show_len;

   // Every 4th correct hit trims the window by one tick, floored at LP_MIN; the next SHOW picks it up.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_show_len <= LP_SHOW;
      end else if ((r_state == ST_OVER) && start) begin
         r_show_len <= LP_SHOW;
      end else if ((r_state == ST_SHOW) && (w_next == ST_HIT) &&
                   (w_score_inc[1:0] == 2'b00) && (r_show_len > LP_MIN)) begin
         r_show_len <= r_show_len - 1'b1;
      end
   end

   assign w_show_len = r_show_len;
`else
   assign w_show_len = (LP_SHOW > LP_MIN) ? LP_SHOW : LP_MIN;
`endif

   assign score       = r_score;
   assign misses      = r_misses;
   assign round_count = r_rounds;

endmodule

// File: tb/tb_mole_round_controller.sv
// Randomized game bench: a round-level game model predicts each outcome; a monitor checks it on hit/miss/over.
`timescale 1ns/1ps
module tb_mole_round_controller;

   localparam int ROUNDS         = 20;
   localparam int MAX_MISSES     = 3;
   localparam int SHOW_TICKS     = 3;
   localparam int GAP_TICKS      = 1;
   localparam int RETRY_MAX      = 3;
   localparam int MIN_SHOW_TICKS = 1;

   logic       CLOCK_50 = 1'b0;
   logic       resetn;
   logic       tick;
   logic       start;
   logic [2:0] box_sel;
   logic       hit_valid;
   logic [2:0] hit_box;
   logic       lfsr_step;
   logic [2:0] active_box;
   logic       flash_en;
   logic       hit_flag;
   logic       miss_flag;
   logic [7:0] score;
   logic [3:0] misses;
   logic [7:0] round_count;
   logic       game_over;

   mole_round_controller #(
      .ROUNDS(ROUNDS), .MAX_MISSES(MAX_MISSES), .SHOW_TICKS(SHOW_TICKS),
      .GAP_TICKS(GAP_TICKS), .RETRY_MAX(RETRY_MAX), .MIN_SHOW_TICKS(MIN_SHOW_TICKS)
   ) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .tick(tick), .start(start),
      .box_sel(box_sel), .hit_valid(hit_valid), .hit_box(hit_box),
      .lfsr_step(lfsr_step), .active_box(active_box), .flash_en(flash_en),
      .hit_flag(hit_flag), .miss_flag(miss_flag), .score(score), .misses(misses),
      .round_count(round_count), .game_over(game_over)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // kind: 0 = miss, 1 = hit, 2 = game over
   typedef struct {
      int kind; int box; int score; int misses; int rounds; int pulses; int ticks;
   } exp_t;

   exp_t exp_q[$];
   int   draw_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   int m_score, m_misses, m_rounds, m_last, m_show_len;
   bit m_over;
   int p_box, p_act, p_k, p_draws, p_wrong, p_show_len;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name, input int waited);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no DUT response after %0d cycles", name, waited);
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #2;
   endtask

   task automatic clr();
      tick      = 1'b0;
      start     = 1'b0;
      hit_valid = 1'b0;
   endtask

   // LFSR stand-in: each request is answered with the next planned draw.
   initial begin
      box_sel = 3'd0;
      forever begin
         @(posedge CLOCK_50);
         #2;
         if (resetn && lfsr_step) begin
            n_cmp++;
            if (draw_q.size() == 0) begin
               n_bad++;
               $display("FAIL draw_request: unplanned lfsr_step, 0 draws queued");
               box_sel = 3'd1;
            end else begin
               box_sel = 3'(draw_q.pop_front());
            end
         end
      end
   end

   initial begin
      int   m_lfsr = 0;
      int   m_ticks = 0;
      bit   p_out = 0;
      bit   p_ov = 0;
      exp_t e;
      forever begin
         @(negedge CLOCK_50);
         if (!resetn) begin
            m_lfsr = 0; m_ticks = 0; p_out = 0; p_ov = 0;
         end else begin
            if (lfsr_step) m_lfsr++;
            if (flash_en && tick) m_ticks++;
            if ((hit_flag || miss_flag) && !p_out) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL outcome_unexpected: hit_flag=%0b miss_flag=%0b with empty queue", hit_flag, miss_flag);
               end else begin
                  e = exp_q.pop_front();
                  chk("outcome_kind", hit_flag ? 1 : 0, e.kind);
                  chk("outcome_box", active_box, e.box);
                  chk("outcome_score", score, e.score);
                  chk("outcome_misses", misses, e.misses);
                  chk("outcome_rounds", round_count, e.rounds);
                  chk("outcome_lfsr_pulses", m_lfsr, e.pulses);
                  chk("outcome_show_ticks", m_ticks, e.ticks);
               end
               m_lfsr = 0; m_ticks = 0;
            end
            if (game_over && !p_ov) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL over_unexpected: game_over rose with empty queue");
               end else begin
                  e = exp_q.pop_front();
                  chk("over_kind", e.kind, 2);
                  chk("over_score", score, e.score);
                  chk("over_misses", misses, e.misses);
                  chk("over_rounds", round_count, e.rounds);
               end
            end
            if (!flash_en && !hit_flag && !miss_flag) chk("dark_active_box", active_box, 0);
            p_out = hit_flag || miss_flag;
            p_ov  = game_over;
         end
      end
   end

   // Plans one round from the game rules and records its expected result.
   task automatic prepare_round(input bit hits_only);
      int v;
      int retries = 0;
      int n = 0;
      int r;
      bit stubborn;
      exp_t e;
      stubborn = (m_last != 0) && ($urandom_range(0, 3) == 0);
      forever begin
         if (stubborn) v = m_last;
         else if ((m_last != 0) && ($urandom_range(0, 2) == 0)) v = m_last;
         else v = $urandom_range(2, 5);
         draw_q.push_back(v);
         n++;
         if ((v == m_last) && (retries < RETRY_MAX)) retries++;
         else break;
      end
      p_box = v; p_draws = n; m_last = v; p_show_len = m_show_len;
      r = $urandom_range(0, 19);
      if (hits_only) p_act = (r < 14) ? 0 : 3;
      else if (r < 9) p_act = 0;
      else if (r < 13) p_act = 3;
      else if (r < 17) p_act = 2;
      else p_act = 1;
      p_k = $urandom_range(0, m_show_len - 1);
      do p_wrong = $urandom_range(1, 7); while (p_wrong == p_box);
      e.box = p_box; e.pulses = n;
      e.ticks = (p_act >= 2) ? m_show_len : p_k;
      m_rounds++;
      if (p_act == 0 || p_act == 3) begin
         e.kind = 1;
         if (m_score < 255) begin
            m_score++;
`ifdef MOLE_SPEEDUP_EN
            if ((m_score % 4 == 0) && (m_show_len > MIN_SHOW_TICKS)) m_show_len--;
`endif
         end
      end else begin
         e.kind = 0;
         m_misses++;
      end
      e.score = m_score; e.misses = m_misses; e.rounds = m_rounds;
      exp_q.push_back(e);
      m_over = (m_misses == MAX_MISSES) || (m_rounds == ROUNDS);
      if (m_over) begin
         e.kind = 2;
         exp_q.push_back(e);
      end
   endtask

   task automatic issue_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
      if ($urandom_range(0, 1) == 1) step();
   endtask

   // Entered in the ARM cycle; returns right after the hit/timeout has been presented.
   task automatic drive_round();
      int cyc = 1;
      int t = 0;
      while (!flash_en && cyc < 100) begin
         step();
         cyc++;
      end
      chk("start_to_flash_cycles", cyc, 2 * p_draws + 1);
      if (!flash_en) return;
      chk("show_active_box", active_box, p_box);
      case (p_act)
         0, 1: begin
            for (int i = 0; i < p_k; i++) issue_tick();
            hit_valid = 1'b1;
            hit_box   = 3'((p_act == 0) ? p_box : p_wrong);
            step();
            clr();
         end
         2: begin
            while (flash_en && t < 40) begin
               tick = 1'b1;
               step();
               tick = 1'b0;
               t++;
               if (flash_en && ($urandom_range(0, 1) == 1)) step();
            end
            chk("timeout_closes_window", flash_en, 0);
         end
         default: begin
            for (int i = 0; i < p_show_len - 1; i++) issue_tick();
            tick      = 1'b1;
            hit_valid = 1'b1;
            hit_box   = 3'(p_box);
            step();
            clr();
         end
      endcase
   endtask

   // Feedback and gap: random ticks plus stray hits/starts that must be ignored.
   task automatic post_phase();
      int c = 0;
      forever begin
         step();
         clr();
         if (lfsr_step || game_over) break;
         c++;
         if (c > 200) begin
            bound_fail("post_round_wait", c);
            break;
         end
         tick = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 5) == 0) begin
            hit_valid = 1'b1;
            hit_box   = 3'($urandom_range(1, 7));
         end
         if ($urandom_range(0, 7) == 0) start = 1'b1;
      end
   endtask

   task automatic run_game(input bit hits_only, input bit mid_reset);
      m_score = 0; m_misses = 0; m_rounds = 0; m_last = 0;
      m_show_len = SHOW_TICKS; m_over = 0;
      prepare_round(hits_only);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("arm_lfsr_step", lfsr_step, 1);
      chk("arm_score_clear", score, 0);
      chk("arm_misses_clear", misses, 0);
      chk("arm_rounds_clear", round_count, 0);
      chk("arm_game_over_low", game_over, 0);
      forever begin
         drive_round();
         if (mid_reset && m_rounds >= 3 && m_score > 0 && !m_over) begin
            @(negedge CLOCK_50);
            #1;
            resetn = 1'b0;
            #1;
            chk("midreset_state_flag", hit_flag | miss_flag | flash_en | game_over | lfsr_step, 0);
            chk("midreset_active_box", active_box, 0);
            chk("midreset_score", score, 0);
            chk("midreset_misses", misses, 0);
            chk("midreset_rounds", round_count, 0);
            chk("scoreboard_drained", exp_q.size(), 0);
            draw_q.delete();
            exp_q.delete();
            return;
         end
         if (m_over) break;
         prepare_round(hits_only);
         post_phase();
         if (!lfsr_step) begin
            bound_fail("next_round_arm", 0);
            return;
         end
      end
      post_phase();
      chk("game_over_reached", game_over, 1);
      hit_valid = 1'b1;
      hit_box   = 3'(p_box);
      tick      = 1'b1;
      step();
      clr();
      step();
      chk("over_hold_score", score, m_score);
      chk("over_hold_misses", misses, m_misses);
      chk("over_hold_rounds", round_count, m_rounds);
      chk("over_hold_flag", game_over, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched so far", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn  = 1'b0;
      hit_box = 3'd0;
      clr();
      repeat (3) @(posedge CLOCK_50);
      #2;
      chk("reset_lfsr_step", lfsr_step, 0);
      chk("reset_active_box", active_box, 0);
      chk("reset_flash_en", flash_en, 0);
      chk("reset_hit_flag", hit_flag, 0);
      chk("reset_miss_flag", miss_flag, 0);
      chk("reset_score", score, 0);
      chk("reset_misses", misses, 0);
      chk("reset_rounds", round_count, 0);
      chk("reset_game_over", game_over, 0);
      resetn = 1'b1;
      step();
      hit_valid = 1'b1;
      hit_box   = 3'd3;
      tick      = 1'b1;
      step();
      clr();
      step();
      chk("idle_ignores_lfsr", lfsr_step, 0);
      chk("idle_ignores_flash", flash_en, 0);
      chk("idle_ignores_score", score, 0);
      chk("idle_ignores_misses", misses, 0);
      run_game(1'b0, 1'b0);
      run_game(1'b1, 1'b0);
      run_game(1'b0, 1'b0);
      run_game(1'b0, 1'b0);
      chk("queue_empty_between_games", exp_q.size(), 0);
      run_game(1'b1, 1'b1);
      resetn = 1'b1;
      repeat (3) step();
      chk("post_reset_idle", lfsr_step | flash_en | game_over, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
